// File: rtl/cpu_pkg.sv
// Shared MIPS core constants and the fetch FSM state encoding (also used by
// the control FSM's debug display).
package cpu_pkg;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned RESET_PC = 0;
  localparam int unsigned INSTR_W  = 32;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT_SPACE,
    FETCH_DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO of {instr, pc} with push/pop/flush and occupancy count.
// Head outputs are combinational from the head entry; flush overrides push/pop.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [1:0]         count_o
);

  logic [INSTR_W-1:0] instr_q [2];
  logic [ADDR_W-1:0]  pc_q    [2];
  logic               wr_q, rd_q;
  logic [1:0]         count_q;
  logic               do_push, do_pop;

  assign do_pop  = pop_i & (count_q != 2'd0);
  assign do_push = push_i & ~flush_i & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        instr_q[wr_q] <= instr_i;
        pc_q[wr_q]    <= pc_i;
      end
      if (flush_i) begin
        wr_q    <= 1'b0;
        rd_q    <= 1'b0;
        count_q <= '0;
      end else begin
        wr_q    <= wr_q ^ do_push;
        rd_q    <= rd_q ^ do_pop;
        count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
    end
  end

  assign instr_o = instr_q[rd_q];
  assign pc_o    = pc_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, imem req/ack master, 2-entry fetch buffer, redirect flush.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  instr_pc4,
  input  logic               instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] target;
  logic [1:0]        count;
  logic              ack, pop, push;

  assign ack    = imem_ack & req_q;
  assign pop    = instr_valid & instr_ready;
  assign target = redirect_pc & ~ADDR_W'(3);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    unique case (state_q)
      FETCH_REQ: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = (req_q && !ack) ? FETCH_DROP : FETCH_REQ;
        end else if (ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          if ({1'b0, count} + 3'd1 - {2'b0, pop} >= 3'd2) state_d = FETCH_WAIT_SPACE;
        end
      end
      FETCH_WAIT_SPACE: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = FETCH_REQ;
        end else if ({1'b0, count} - {2'b0, pop} < 3'd2) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (redirect) fetch_pc_d = target;
        if (ack) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_REQ;
    endcase
    // DROP keeps the abandoned address on the bus until its ack arrives.
    req_d  = (state_d != FETCH_WAIT_SPACE);
    addr_d = (state_d == FETCH_DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH_REQ;
      req_q      <= 1'b0;
      addr_q     <= ADDR_W'(RESET_PC);
      fetch_pc_q <= ADDR_W'(RESET_PC);
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  fetch_buffer #(
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .instr_i (imem_rdata),
    .pc_i    (addr_q),
    .instr_o (instr),
    .pc_o    (instr_pc),
    .count_o (count)
  );

  assign instr_valid = (count != 2'd0);
  assign instr_pc4   = instr_pc + ADDR_W'(4);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push && perf_fetched_q != '1) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (instr_ready && !instr_valid && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  // Counters are absent in this build; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: vector table plus redirect/wrap/perf sequences.
module tb_instr_fetch;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req, imem_ack = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata, instr;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_valid, instr_ready = 1'b0;
  logic [AW-1:0] instr_pc, instr_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word encodes its own address.
  assign imem_rdata = 32'hC0DE_0000 | {22'd0, imem_addr};

  instr_fetch #(
    .ADDR_W  (AW),
    .RESET_PC(0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_pc4  (instr_pc4),
    .instr_ready(instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  typedef struct {
    logic          rst, ack, rdy;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic y, input logic d,
                       input logic [AW-1:0] rp);
    @(negedge clk);
    reset = r; imem_ack = a; instr_ready = y; redirect = d; redirect_pc = rp;
    #1;
  endtask

  task automatic expect_out(input string name, input logic req, input logic [AW-1:0] addr,
                            input logic valid, input logic [AW-1:0] pc);
    logic [AW-1:0] pc4;
    pc4 = pc + 10'd4;
    chk({name, ".req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({name, ".addr"}, {22'd0, imem_addr}, {22'd0, addr});
    chk({name, ".valid"}, {31'd0, instr_valid}, {31'd0, valid});
    if (valid) begin
      chk({name, ".pc"}, {22'd0, instr_pc}, {22'd0, pc});
      chk({name, ".pc4"}, {22'd0, instr_pc4}, {22'd0, pc4});
      chk({name, ".instr"}, instr, 32'hC0DE_0000 | {22'd0, pc});
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // rst ack rdy | req addr valid pc
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h000, 1'b0, 10'h000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h004, 1'b1, 10'h000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h008, 1'b1, 10'h004};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h00C, 1'b1, 10'h008};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'h010, 1'b1, 10'h00C};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 10'h000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'h004, 1'b1, 10'h000};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h008, 1'b1, 10'h000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10'h008, 1'b1, 10'h000};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'h008, 1'b1, 10'h000};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h008, 1'b1, 10'h004};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h00C, 1'b1, 10'h008};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'h010, 1'b1, 10'h00C};

    do_reset();
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.addr", {22'd0, imem_addr}, 32'd0);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.instr", instr, 32'd0);
    chk("rst.pc", {22'd0, instr_pc}, 32'd0);
    chk("rst.pc4", {22'd0, instr_pc4}, 32'd4);

    // Streaming, stall-fill, then release.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].rdy, 1'b0, '0);
      expect_out($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
                 tbl[i].exp_valid, tbl[i].exp_pc);
    end

    // Redirect while a slow read is outstanding: old read dropped.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h123);
    expect_out("drop.c1", 1'b1, 10'h000, 1'b0, 10'h000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    expect_out("drop.c2", 1'b1, 10'h000, 1'b0, 10'h000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    expect_out("drop.c3", 1'b1, 10'h000, 1'b0, 10'h000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("drop.c4", 1'b1, 10'h000, 1'b0, 10'h000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    expect_out("drop.c5", 1'b1, 10'h120, 1'b0, 10'h000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("drop.c6", 1'b1, 10'h120, 1'b0, 10'h000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    expect_out("drop.c7", 1'b1, 10'h124, 1'b1, 10'h120);

    // Redirect coinciding with ack of 0x008 and pop of 0x004, then wrap at top of memory.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'h040);
    expect_out("rda.c3", 1'b1, 10'h008, 1'b1, 10'h004);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("rda.c4", 1'b1, 10'h040, 1'b0, 10'h000);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'h3F8);
    expect_out("rda.c5", 1'b1, 10'h044, 1'b1, 10'h040);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("wrap.c6", 1'b1, 10'h3F8, 1'b0, 10'h000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("wrap.c7", 1'b1, 10'h3FC, 1'b1, 10'h3F8);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("wrap.c8", 1'b1, 10'h000, 1'b1, 10'h3FC);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    expect_out("wrap.c9", 1'b1, 10'h004, 1'b1, 10'h000);

`ifdef FETCH_PERF_EN
    // 10 pushes, then 4 starved cycles with ready high.
    do_reset();
    for (int p = 0; p < 17; p++)
      drive(1'b0, (p <= 11), (p >= 3 && p <= 16), 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("perf.fetched", perf_fetched, 32'd10);
    chk("perf.stall", perf_stall, 32'd4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("perf.fetched_rst", perf_fetched, 32'd0);
    chk("perf.stall_rst", perf_stall, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the multicycle MIPS core. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Fetched words go into a 2-entry buffer, and the control FSM's IFetch/Decode stages pop them as (instr, pc, pc+4) triples. Jump/branch redirects from Execute/Writeback flush the buffer and any in-flight read.

## Interface
- `ADDR_W`, 10: PC / instruction address width in bits (byte address)
- `RESET_PC`, 0: PC loaded on reset; bits [1:0] must be 0
- `clk` in 1: single clock, all state on posedge
- `reset` in 1: synchronous, active-high
- `imem_req` out 1: read request; held with `imem_addr` stable until acked
- `imem_addr` out ADDR_W: word-aligned byte address of the read
- `imem_ack` in 1: read complete this cycle; sampled only while `imem_req`=1
- `imem_rdata` in 32: instruction word, valid in the `imem_ack` cycle
- `redirect` in 1: one-cycle pulse, new fetch target
- `redirect_pc` in ADDR_W: target; bits [1:0] ignored and forced to 00
- `instr_valid` out 1: buffer head valid
- `instr` out 32: head instruction word
- `instr_pc` out ADDR_W: address of head
- `instr_pc4` out ADDR_W: `instr_pc`+4, mod 2^ADDR_W
- `instr_ready` in 1: consumer pops the head when `instr_valid`&`instr_ready`

## Operation
- State: `fetch_pc` (next address to request), 2-entry FIFO, FSM {REQ, WAIT_SPACE, DROP}.
- REQ: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - On ack, push {rdata, fetch_pc} and set `fetch_pc`+=4.
  - Then stay in REQ if the FIFO count after this cycle's push/pop is <2; otherwise go to WAIT_SPACE.
- WAIT_SPACE: `imem_req`=0. Go to REQ once the count after this cycle's pop is <2.
- DROP: `imem_req`=1 with the old address held stable. On ack, discard rdata (no push) and go to REQ.
- Redirect:
  - FIFO is cleared; a pop in the same cycle still counts as accepted by the consumer, then the flush applies.
  - `fetch_pc` ← `redirect_pc` & ~3.
  - From REQ without ack in the same cycle: go to DROP.
  - From REQ with ack in the same cycle: discard that data, go to REQ.
  - From WAIT_SPACE or DROP: go to REQ, or stay in DROP if the outstanding read has not been acked yet.
- PC arithmetic wraps modulo 2^ADDR_W (0x3FC+4 → 0x000). No error is raised.
- Push and pop in the same cycle on a full FIFO are legal: the count is unchanged and order is preserved.
- FIFO is strictly in order; the head outputs are combinational from the head entry.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, `instr_pc4`=4
  - FSM=REQ, `fetch_pc`=RESET_PC, FIFO empty.
- First request: `imem_req`=1 in the first cycle after `reset` deasserts.
- Latency: ack at edge N gives `instr_valid`=1 in cycle N+1.
- Throughput:
  - Zero-wait memory (ack tied high) with `instr_ready`=1 sustains 1 instr/cycle.
  - A stalled consumer fills the FIFO in 2 acks, then `imem_req` drops.
- After a redirect pulse at edge N, `instr_valid`=0 in cycle N+1. The first redirected request issues in cycle N+1 (from REQ/WAIT_SPACE) or after the pending ack (DROP).
- `reset` mid-transaction abandons any outstanding read; the memory must tolerate a dropped request.

## Configuration
- `FETCH_PERF_EN` defined: adds `perf_fetched` out 32 and `perf_stall` out 32.
  - `perf_fetched` counts pushes.
  - `perf_stall` counts cycles with `instr_ready`=1 & `instr_valid`=0.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `cpu_pkg` holds `ADDR_W`, `RESET_PC`, the instruction word width (32), and the fetch FSM state enum shared with the control FSM's debug display.
- One sub-module, `fetch_buffer`: a 2-entry synchronous FIFO with push/pop/flush, carrying {instr[31:0], pc[ADDR_W-1:0]}, with count output.

## Test plan
- Reset, ack tied 1, ready 1 → addrs 0x000, 0x004, 0x008… on consecutive cycles; `instr_pc` follows one cycle later; `instr_pc4` = `instr_pc`+4.
- Ready held 0, ack 1 → exactly 2 pushes (pc 0x000, 0x004), then `imem_req`=0. Raise ready → pops 0x000, 0x004, and a request for 0x008 issues.
- Ack delayed 3 cycles, redirect to 0x123 in cycle 1 → `imem_addr` stays 0x000 until ack, that data is discarded, the next request is 0x120, and no instruction from 0x000 appears.
- Redirect to 0x040 in the same cycle as ack of 0x008 and pop of 0x004 → 0x004 consumed, 0x008 dropped, FIFO empty, next request 0x040.
- Redirect to 0x3F8 with ack 1 → fetches 0x3F8, 0x3FC, 0x000 (wrap).
- `FETCH_PERF_EN` defined: 10 pushes and 4 starved cycles → `perf_fetched`=10, `perf_stall`=4; reset mid-run → both read 0.
